lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
Parametrised HD44780-class character LCD controller; next generation of the team's fixed-string LCD driver.
- After reset, runs a power-up wait and a built-in init command sequence.
- Then accepts arbitrary command/data bytes from upstream over a valid/ready handshake.
- Generates rs/rw/en/data with programmable setup, enable-pulse and execution-wait timing, in 8-bit or 4-bit bus mode.
- Sits between the system logic (text/menu generator) and the LCD pins.

Parameters:
BUS_4BIT, 0, 1 = 4-bit bus mode (two nibble transfers per byte, high nibble first); 0 = 8-bit.
POWERUP_CYC, 1000, clk cycles waited after reset before the first init transfer.
SETUP_CYC, 2, cycles rs/d are stable with en low before each en rising edge (min 1).
EN_PULSE_CYC, 10, cycles en is held high per transfer (min 1).
CMD_WAIT_CYC, 50, cycles en stays low after a byte completes, before the next transfer.
CLEAR_WAIT_CYC, 2000, post-byte wait used instead of CMD_WAIT_CYC for commands 0x01 and 0x02.
COLS, 16, characters per line (LINE_WRAP_EN only).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream byte valid
in_ready  output  1  controller can accept a byte this cycle
in_rs  input  1  0 = command, 1 = character data
in_byte  input  8  byte to write
init_done  output  1  init sequence complete (sticky until reset)
busy  output  1  transfer or wait in progress (includes init)
lcd_rs  output  1  LCD register select
lcd_rw  output  1  LCD read/write; always 0 (write-only controller)
lcd_en  output  1  LCD enable strobe
lcd_d  output  8  LCD data bus; in 4-bit mode nibble on [7:4], [3:0] driven 0

Behaviour:
- Reset (async assert, sync deassert inside block): lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_d=0x00, in_ready=0, init_done=0, busy=1. State goes to PWR_WAIT, all counters cleared.
- Reset mid-transfer aborts immediately: en drops in the same instant, no partial byte is completed, and full init re-runs.
- States: PWR_WAIT -> INIT_LOAD -> SETUP -> PULSE -> GAP -> (INIT_LOAD | IDLE).
  - PWR_WAIT: count POWERUP_CYC.
  - INIT_LOAD: fetch next init table entry.
  - SETUP: drive rs/d, en=0, SETUP_CYC cycles.
  - PULSE: en=1, EN_PULSE_CYC cycles.
  - GAP: en=0, rs/d held. In 4-bit mode after the high nibble, GAP lasts SETUP_CYC, then the low nibble runs SETUP/PULSE. After the final nibble, GAP lasts CMD_WAIT_CYC, or CLEAR_WAIT_CYC if the byte is command 0x01/0x02.
- Init table, all rs=0:
  - 8-bit: 0x38, 0x01, 0x0E, 0x06, 0x80.
  - 4-bit: a single high-nibble-only transfer 0x2, then 0x28, 0x01, 0x0E, 0x06, 0x80.
- init_done rises on the first cycle of IDLE after the last init entry's GAP.
- IDLE: in_ready=1, busy=0. Accept when in_valid && in_ready. in_rs/in_byte are captured that edge. in_ready and busy change on the next cycle (in_ready=0, busy=1), and SETUP starts.
- Bytes offered while in_ready=0 are not accepted; upstream must hold them.
- in_ready is never high before init_done.
- Byte latency, accept to en rise: SETUP_CYC+1 cycles.
- Full 8-bit byte period: 1 + SETUP_CYC + EN_PULSE_CYC + wait.
- lcd_rs and lcd_d change only while en is low, never in the cycle en falls.

Optional Feature:
LCD_LINE_WRAP_EN.
- Defined:
  - A column counter (0..COLS-1) and a line bit track the cursor.
  - Each accepted data byte (rs=1) increments the column.
  - After the COLS-th character, the controller inserts command 0xC0 (line 0->1) or 0x80 (line 1->0) before returning to IDLE. in_ready stays low through the inserted command.
  - Accepted commands 0x01/0x02 reset column and line to 0.
  - Command 0x80|a sets line=a[6], col=a[3:0].
- Not defined: no counter, no inserted commands; bytes pass through verbatim.

Test Plan:
1. Reset with POWERUP_CYC=20, BUS_4BIT=0 -> no en pulse for 20 cycles; then exactly 5 en pulses carrying 0x38, 0x01, 0x0E, 0x06, 0x80 with rs=0. Gap after 0x01 is CLEAR_WAIT_CYC; init_done=1 after the last gap.
2. Post-init, send rs=1 byte 0x76 -> en high exactly EN_PULSE_CYC=10 cycles, rising SETUP_CYC+1=3 cycles after accept, with lcd_rs=1 and lcd_d=0x76 stable during en. in_ready returns after CMD_WAIT_CYC.
3. BUS_4BIT=1, send data 0xA5 -> two en pulses, lcd_d[7:4]=0xA then 0x5, lcd_d[3:0]=0. Init stream begins with a single 0x2 nibble, then 0x2/0x8.
4. in_valid held high with 3 queued bytes -> each accepted only when in_ready=1; no byte lost or duplicated; rw is 0 throughout.
5. Assert rst_n low during the PULSE of a data byte -> lcd_en=0 and all outputs at reset values immediately; full init repeats after release.
6. LCD_LINE_WRAP_EN, COLS=4: send 5 chars -> after char 4, inserted rs=0 byte 0xC0; char 5 then follows. After 4 more chars, 0x80 is inserted.

Source files
------------

// File: rtl/lcd_ctrl_if.sv
// Upstream byte handshake for lcd_ctrl: the text/menu generator is the
// master, the LCD controller is the slave.
interface lcd_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_byte;

  modport master (output in_valid, output in_rs, output in_byte, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_byte, output in_ready);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-class character LCD controller.
// Power-up wait, built-in init sequence, then upstream command/data bytes
// are written with programmable setup / enable-pulse / execution-wait timing,
// in 8-bit or 4-bit (high nibble first on lcd_d[7:4]) bus mode.
// Optional feature macro LCD_LINE_WRAP_EN: tracks the cursor column/line and
// inserts a set-DDRAM-address command after every COLS-th character.
module lcd_ctrl #(
  parameter int BUS_4BIT       = 0,
  parameter int POWERUP_CYC    = 1000,
  parameter int SETUP_CYC      = 2,
  parameter int EN_PULSE_CYC   = 10,
  parameter int CMD_WAIT_CYC   = 50,
  parameter int CLEAR_WAIT_CYC = 2000,
  parameter int COLS           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  lcd_ctrl_if.slave  up,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_d
);

  typedef enum logic [2:0] {PWR_WAIT, INIT_LOAD, SETUP, PULSE, GAP, IDLE} state_t;

  localparam logic [31:0] PWR_L = 32'(POWERUP_CYC);
  localparam logic [31:0] SET_L = 32'(SETUP_CYC);
  localparam logic [31:0] PUL_L = 32'(EN_PULSE_CYC);
  localparam logic [31:0] CMD_L = 32'(CMD_WAIT_CYC);
  localparam logic [31:0] CLR_L = 32'(CLEAR_WAIT_CYC);
  localparam logic [2:0]  INIT_LEN = (BUS_4BIT != 0) ? 3'd6 : 3'd5;

  // 4-bit mode prepends a lone 0x2 nibble (function-set to 4-bit) before the
  // regular table; it is stored as 0x20 and flagged high-nibble-only.
  function automatic logic [7:0] init_rom(input logic [2:0] i);
    logic [7:0] v;
    logic [2:0] j;
    j = (BUS_4BIT != 0) ? i - 3'd1 : i;
    case (j)
      3'd0:    v = (BUS_4BIT != 0) ? 8'h28 : 8'h38;
      3'd1:    v = 8'h01;
      3'd2:    v = 8'h0E;
      3'd3:    v = 8'h06;
      default: v = 8'h80;
    endcase
    if (BUS_4BIT != 0 && i == 3'd0) v = 8'h20;
    return v;
  endfunction

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic        rs_q, rs_n;
  logic [7:0]  byte_q, byte_n;
  logic [7:0]  d_q, d_n;
  logic        hi_ph, hi_n;
  logic        hi_only, ho_n;
  logic        in_init, ini_n;
  logic        done_q, done_n;
  logic [31:0] gap_len;
  logic        ld, ld_rs, ld_ho;
  logic [7:0]  ld_byte;
  logic [1:0]  rst_sync;
  logic        arst_n;

`ifdef LCD_LINE_WRAP_EN
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  logic [CW-1:0] col, col_n;
  logic          line, line_n;
  logic          wrap_pend, wp_n;
`endif

  // Reset asserts immediately and releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign arst_n = rst_sync[1];

  // Post-byte wait: short inter-nibble gap, long wait for clear/home, else command wait.
  always_comb begin
    if (hi_ph && !hi_only)                              gap_len = SET_L;
    else if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) gap_len = CLR_L;
    else                                                gap_len = CMD_L;
  end

  // Next-state and datapath: sequencing of init table, user bytes and nibbles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 32'd1;
    idx_n   = idx;
    rs_n    = rs_q;
    byte_n  = byte_q;
    d_n     = d_q;
    hi_n    = hi_ph;
    ho_n    = hi_only;
    ini_n   = in_init;
    done_n  = done_q;
    ld      = 1'b0;
    ld_rs   = 1'b0;
    ld_byte = 8'h00;
    ld_ho   = 1'b0;
`ifdef LCD_LINE_WRAP_EN
    col_n   = col;
    line_n  = line;
    wp_n    = wrap_pend;
`endif
    case (state)
      PWR_WAIT: if (cnt + 32'd1 >= PWR_L) begin state_n = INIT_LOAD; cnt_n = '0; end
      INIT_LOAD: begin
        ld      = 1'b1;
        ld_byte = init_rom(idx);
        ld_ho   = (BUS_4BIT != 0) && (idx == 3'd0);
        idx_n   = idx + 3'd1;
      end
      SETUP: if (cnt + 32'd1 >= SET_L) begin state_n = PULSE; cnt_n = '0; end
      PULSE: if (cnt + 32'd1 >= PUL_L) begin state_n = GAP; cnt_n = '0; end
      GAP: if (cnt + 32'd1 >= gap_len) begin
        cnt_n = '0;
        if (hi_ph && !hi_only) begin
          state_n = SETUP;
          hi_n    = 1'b0;
          d_n     = {byte_q[3:0], 4'h0};
        end else if (in_init) begin
          if (idx == INIT_LEN) begin
            state_n = IDLE;
            ini_n   = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = INIT_LOAD;
          end
        end else begin
`ifdef LCD_LINE_WRAP_EN
          if (wrap_pend) begin
            ld      = 1'b1;
            ld_byte = line ? 8'h80 : 8'hC0;
            line_n  = ~line;
            wp_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end
      end
      IDLE: if (up.in_valid) begin
        ld      = 1'b1;
        ld_rs   = up.in_rs;
        ld_byte = up.in_byte;
`ifdef LCD_LINE_WRAP_EN
        if (up.in_rs) begin
          if (col == COL_MAX) begin col_n = '0; wp_n = 1'b1; end
          else                  col_n = col + 1'b1;
        end else if (up.in_byte == 8'h01 || up.in_byte == 8'h02) begin
          col_n  = '0;
          line_n = 1'b0;
        end else if (up.in_byte[7]) begin
          line_n = up.in_byte[6];
          col_n  = CW'(up.in_byte[3:0]);
        end
`endif
      end
      default: state_n = PWR_WAIT;
    endcase
    // Loading a byte: bus values change here, always while en is low.
    if (ld) begin
      state_n = SETUP;
      cnt_n   = '0;
      rs_n    = ld_rs;
      byte_n  = ld_byte;
      ho_n    = ld_ho;
      hi_n    = (BUS_4BIT != 0);
      d_n     = (BUS_4BIT != 0) ? {ld_byte[7:4], 4'h0} : ld_byte;
    end
  end

  // State and datapath registers; reset aborts any transfer and re-runs init.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      idx       <= '0;
      rs_q      <= 1'b0;
      byte_q    <= 8'h00;
      d_q       <= 8'h00;
      hi_ph     <= 1'b0;
      hi_only   <= 1'b0;
      in_init   <= 1'b1;
      done_q    <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
      col       <= '0;
      line      <= 1'b0;
      wrap_pend <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      rs_q      <= rs_n;
      byte_q    <= byte_n;
      d_q       <= d_n;
      hi_ph     <= hi_n;
      hi_only   <= ho_n;
      in_init   <= ini_n;
      done_q    <= done_n;
`ifdef LCD_LINE_WRAP_EN
      col       <= col_n;
      line      <= line_n;
      wrap_pend <= wp_n;
`endif
    end
  end

  assign lcd_en      = (state == PULSE);
  assign lcd_rs      = rs_q;
  assign lcd_d       = d_q;
  assign lcd_rw      = 1'b0;
  assign busy        = (state != IDLE);
  assign up.in_ready = (state == IDLE);
  assign init_done   = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: one 8-bit instance (COLS=4) and one 4-bit
// instance. Stimulus pushes expected en pulses; a monitor pops on each falling
// en and checks rs/d, pulse width, bus stability, low gap and rise latency.
module tb_lcd_ctrl;
  localparam int S = 2, P = 10, W = 50, CLR = 300, PWR = 20;
  localparam int G = W + 1 + S;

  typedef struct packed {
    logic       rs;
    logic [7:0] d;
    int         gap;   // expected en-low cycles before this pulse, -1 = don't care
    int         rise;  // expected cycle of en rise, -1 = don't care
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8_n, rst4_n;
  logic done8, busy8, rs8, rw8, en8;
  logic done4, busy4, rs4, rw4, en4;
  logic [7:0] d8, d4;

  lcd_ctrl_if if8();
  lcd_ctrl_if if4();

  lcd_ctrl #(.BUS_4BIT(0), .POWERUP_CYC(PWR), .SETUP_CYC(S), .EN_PULSE_CYC(P),
             .CMD_WAIT_CYC(W), .CLEAR_WAIT_CYC(CLR), .COLS(4)) dut8 (
    .clk(clk), .rst_n(rst8_n), .up(if8), .init_done(done8), .busy(busy8),
    .lcd_rs(rs8), .lcd_rw(rw8), .lcd_en(en8), .lcd_d(d8));

  lcd_ctrl #(.BUS_4BIT(1), .POWERUP_CYC(PWR), .SETUP_CYC(S), .EN_PULSE_CYC(P),
             .CMD_WAIT_CYC(W), .CLEAR_WAIT_CYC(CLR), .COLS(16)) dut4 (
    .clk(clk), .rst_n(rst4_n), .up(if4), .init_done(done4), .busy(busy4),
    .lcd_rs(rs4), .lcd_rw(rw4), .lcd_en(en4), .lcd_d(d4));

  exp_t q0[$], q1[$];
  int checks = 0, errors = 0, cyc = 0, rw_err = 0, rdy_err = 0;
  int mcol = 0;
  bit mline = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic rdy(input int i);
    return (i == 0) ? if8.in_ready : if4.in_ready;
  endfunction

  // ---------------- monitor ----------------
  logic [1:0] m_en, m_rs, m_rw, m_rdy, m_done, m_rst;
  logic [7:0] m_d[2];
  assign m_en   = {en4, en8};
  assign m_rs   = {rs4, rs8};
  assign m_rw   = {rw4, rw8};
  assign m_rdy  = {if4.in_ready, if8.in_ready};
  assign m_done = {done4, done8};
  assign m_rst  = {rst4_n, rst8_n};
  assign m_d[0] = d8;
  assign m_d[1] = d4;

  int plen[2], lowlen[2], glow[2], rcyc[2];
  logic inp[2], stab[2], prs[2];
  logic [7:0] pd[2];

  always @(negedge clk) begin : mon
    exp_t e;
    bit hit;
    for (int i = 0; i < 2; i++) begin
      if (!m_rst[i]) begin
        inp[i] = 1'b0;
        lowlen[i] = -1;
      end else begin
        if (m_rw[i]) rw_err++;
        if (m_rdy[i] && !m_done[i]) rdy_err++;
        if (m_en[i]) begin
          if (!inp[i]) begin
            inp[i] = 1'b1; plen[i] = 1; pd[i] = m_d[i]; prs[i] = m_rs[i];
            rcyc[i] = cyc; stab[i] = 1'b1; glow[i] = lowlen[i];
          end else begin
            plen[i]++;
            if (m_d[i] !== pd[i] || m_rs[i] !== prs[i]) stab[i] = 1'b0;
          end
        end else if (inp[i]) begin
          if (m_d[i] !== pd[i] || m_rs[i] !== prs[i]) stab[i] = 1'b0;
          inp[i] = 1'b0;
          lowlen[i] = 1;
          hit = 1'b0;
          if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); hit = 1'b1; end
          else if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); hit = 1'b1; end
          if (!hit) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse dut%0d: got rs=%0d d=0x%02h expected no pulse", i, prs[i], pd[i]);
          end else begin
            chk($sformatf("pulse_rs dut%0d d=%02h", i, e.d), int'(prs[i]), int'(e.rs));
            chk($sformatf("pulse_d dut%0d", i), int'(pd[i]), int'(e.d));
            chk($sformatf("pulse_len dut%0d d=%02h", i, e.d), plen[i], P);
            chk($sformatf("bus_stable dut%0d d=%02h", i, e.d), int'(stab[i]), 1);
            if (e.gap >= 0) chk($sformatf("low_gap dut%0d d=%02h", i, e.d), glow[i], e.gap);
            if (e.rise >= 0) chk($sformatf("rise_cyc dut%0d d=%02h", i, e.d), rcyc[i], e.rise);
          end
        end else if (lowlen[i] >= 0) begin
          lowlen[i]++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_init(input int i);
    if (i == 0) begin
      mcol = 0; mline = 1'b0;
      q0.push_back('{1'b0, 8'h38, -1, -1});
      q0.push_back('{1'b0, 8'h01, G, -1});
      q0.push_back('{1'b0, 8'h0E, CLR + 1 + S, -1});
      q0.push_back('{1'b0, 8'h06, G, -1});
      q0.push_back('{1'b0, 8'h80, G, -1});
    end else begin
      q1.push_back('{1'b0, 8'h20, -1, -1});
      q1.push_back('{1'b0, 8'h20, G, -1});
      q1.push_back('{1'b0, 8'h80, 2 * S, -1});
      q1.push_back('{1'b0, 8'h00, G, -1});
      q1.push_back('{1'b0, 8'h10, 2 * S, -1});
      q1.push_back('{1'b0, 8'h00, CLR + 1 + S, -1});
      q1.push_back('{1'b0, 8'hE0, 2 * S, -1});
      q1.push_back('{1'b0, 8'h00, G, -1});
      q1.push_back('{1'b0, 8'h60, 2 * S, -1});
      q1.push_back('{1'b0, 8'h80, G, -1});
      q1.push_back('{1'b0, 8'h00, 2 * S, -1});
    end
  endtask

  task automatic push_byte(input int i, input logic rs, input logic [7:0] b, input int k);
    if (i == 1) begin
      q1.push_back('{rs, {b[7:4], 4'h0}, -1, k + S + 1});
      q1.push_back('{rs, {b[3:0], 4'h0}, 2 * S, -1});
    end else begin
      q0.push_back('{rs, b, -1, k + S + 1});
`ifdef LCD_LINE_WRAP_EN
      if (rs) begin
        mcol++;
        if (mcol == 4) begin
          q0.push_back('{1'b0, (mline ? 8'h80 : 8'hC0), W + S, -1});
          mline = ~mline;
          mcol = 0;
        end
      end else if (b == 8'h01 || b == 8'h02) begin
        mcol = 0; mline = 1'b0;
      end else if (b[7]) begin
        mline = b[6]; mcol = int'(b[1:0]);
      end
`endif
    end
  endtask

  // Called at a negedge; leaves in_valid high so callers can queue back-to-back.
  task automatic send(input int i, input logic rs, input logic [7:0] b, input bit push);
    int n = 0;
    if (i == 0) begin if8.in_valid = 1'b1; if8.in_rs = rs; if8.in_byte = b; end
    else        begin if4.in_valid = 1'b1; if4.in_rs = rs; if4.in_byte = b; end
    while (!rdy(i) && n < 3000) begin @(negedge clk); n++; end
    if (!rdy(i)) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: got no in_ready expected accept of 0x%02h", i, b);
      return;
    end
    if (push) push_byte(i, rs, b, cyc);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int i, input string nm);
    int n = 0;
    while (!(rdy(i) && ((i == 0) ? q0.size() : q1.size()) == 0) && n < 6000) begin
      @(negedge clk); n++;
    end
    chk($sformatf("%s ready dut%0d", nm, i), int'(rdy(i)), 1);
    chk($sformatf("%s init_done dut%0d", nm, i), int'((i == 0) ? done8 : done4), 1);
    chk($sformatf("%s busy dut%0d", nm, i), int'((i == 0) ? busy8 : busy4), 0);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " en"}, int'(en8), 0);
    chk({nm, " rs"}, int'(rs8), 0);
    chk({nm, " rw"}, int'(rw8), 0);
    chk({nm, " d"}, int'(d8), 0);
    chk({nm, " ready"}, int'(if8.in_ready), 0);
    chk({nm, " init_done"}, int'(done8), 0);
    chk({nm, " busy"}, int'(busy8), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    int n;
    rst8_n = 1'b0; rst4_n = 1'b0;
    if8.in_valid = 1'b0; if8.in_rs = 1'b0; if8.in_byte = 8'h00;
    if4.in_valid = 1'b0; if4.in_rs = 1'b0; if4.in_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    chk("reset dut4 busy", int'(busy4), 1);
    chk("reset dut4 ready", int'(if4.in_ready), 0);

    // power-up quiet period and init streams
    push_init(0); push_init(1);
    rst8_n = 1'b1; rst4_n = 1'b1;
    n = 0;
    repeat (PWR) begin @(negedge clk); if (en8 || en4) n++; end
    chk("powerup_quiet", n, 0);
    chk("init_done_low_during_init", int'(done8), 0);
    wait_idle(0, "init");
    wait_idle(1, "init");

    // single data byte, then in_ready returns after the command wait
    send(0, 1'b1, 8'h76, 1'b1);
    if8.in_valid = 1'b0;
    n = 0;
    while (!en8 && n < 100) begin @(negedge clk); n++; end
    while (en8 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!if8.in_ready && n < 1000) begin @(negedge clk); n++; end
    chk("ready_after_cmd_wait", n, W);

    // in_valid held across three queued bytes
    send(0, 1'b1, 8'h41, 1'b1);
    send(0, 1'b0, 8'h01, 1'b1);
    send(0, 1'b1, 8'h42, 1'b1);
    if8.in_valid = 1'b0;
    wait_idle(0, "queued");

    // 4-bit nibble split
    send(1, 1'b1, 8'hA5, 1'b1);
    if4.in_valid = 1'b0;
    send(1, 1'b0, 8'h0C, 1'b1);
    if4.in_valid = 1'b0;
    wait_idle(1, "nibble");

    // reset in the middle of a data pulse
    send(0, 1'b1, 8'h33, 1'b0);
    if8.in_valid = 1'b0;
    n = 0;
    while (!en8 && n < 100) begin @(negedge clk); n++; end
    chk("abort_pulse_seen", int'(en8), 1);
    repeat (3) @(negedge clk);
    rst8_n = 1'b0;
    #1;
    chk_reset_state("abort");
    push_init(0);
    repeat (2) @(negedge clk);
    rst8_n = 1'b1;
    n = 0;
    repeat (PWR) begin @(negedge clk); if (en8) n++; end
    chk("reinit_quiet", n, 0);
    wait_idle(0, "reinit");

`ifdef LCD_LINE_WRAP_EN
    // line wrap: 0xC0 after 4th char, 0x80 after 8th
    for (int c = 0; c < 8; c++) begin
      send(0, 1'b1, 8'h61 + 8'(c), 1'b1);
      if8.in_valid = 1'b0;
    end
    wait_idle(0, "wrap");
`endif

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 5000) begin @(negedge clk); n++; end
    chk("scoreboard_empty dut0", q0.size(), 0);
    chk("scoreboard_empty dut1", q1.size(), 0);
    chk("rw_always_zero", rw_err, 0);
    chk("ready_before_init_done", rdy_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
